// File: rtl/uart_autobaud_ctrl.sv
// uart_autobaud_ctrl
//   Measures a 0x55 sync character on rx and derives the baud divisor and
//   3-bit fraction for the UART baud clock generator. It then loads the
//   new values and restarts the generator. In manual mode it passes the
//   register values through.
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   rx                 asynchronous serial line (idle high)
//   autobaud_en        1 = autobaud, 0 = manual pass-through
//   start              one-cycle pulse arming a measurement (ignored while busy)
//   cfg_baud_val/frac  manual-mode divisor / fraction
//   baud_val/fraction  values driven to the clock generator
//   gen_rst_n          one-cycle low restart strobe, issued with every value load
//   busy               measurement in progress
//   done / err         one-cycle result pulses
module uart_autobaud_ctrl #(
  parameter logic [12:0] DEFAULT_BAUD_VAL = 13'd26,
  parameter int          IDLE_CYCLES      = 64,
  parameter int          CNT_W            = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        autobaud_en,
  input  logic        start,
  input  logic [12:0] cfg_baud_val,
  input  logic [2:0]  cfg_fraction,
  output logic [12:0] baud_val,
  output logic [2:0]  baud_val_fraction,
  output logic        gen_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int QW = $clog2(IDLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_QUIET, S_ARMED, S_MEASURE, S_CALC, S_LOAD
  } state_e;

  state_e state_q, state_d;

  logic             rx_s1_q, rx_s2_q, rx_h_q;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic [1:0]       ecnt_q, ecnt_d;
  logic [12:0]      baud_q, baud_d;
  logic [2:0]       frac_q, frac_d;
  logic             gen_rst_n_q, gen_rst_n_d;
  logic             err_q, err_d;

  // ---------------------------------------------------------------------
  // rx synchroniser + history flop. These flops reset high so that a reset
  // while the line idles does not create a false falling edge.
  // ---------------------------------------------------------------------
  logic fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_h_q  <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_h_q  <= rx_s2_q;
    end
  end

  assign fall = rx_h_q & ~rx_s2_q;

  // ---------------------------------------------------------------------
  // Measurement arithmetic
  // ---------------------------------------------------------------------
  logic [CNT_W:0]   tr;
  logic [CNT_W-1:0] t_inc;
  logic             t_ovf;
  logic             final_edge;
  logic             too_fast;
  logic [12:0]      div;
  logic             unused_tr_bits;

  // Adding 8 before truncating to 1/8-bit resolution rounds to nearest.
  // The generator bit time is 16*(baud_val+1) + 2*fraction, so 8 bit
  // times = 128*(baud_val+1) + 16*fraction.
  assign tr         = {1'b0, t_q} + (CNT_W+1)'(8);
  assign div        = 13'(tr[CNT_W-1:7]);
  assign too_fast   = (tr[CNT_W-1:7] == '0);
  assign t_inc      = t_q + CNT_W'(1);
  // Reaching all-ones counts as overflow, so the largest T latched is 2^CNT_W-2.
  assign t_ovf      = (t_inc == '1);
  // The start edge is not counted. The 4th falling edge after it is the
  // falling edge of data bit 7, which is 8 bit times later.
  assign final_edge = fall && (ecnt_q == 2'd3);
  assign unused_tr_bits = ^{tr[CNT_W], tr[3:0]};

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start && autobaud_en) state_d = S_QUIET;
      S_QUIET: begin
        if (!autobaud_en)                                       state_d = S_IDLE;
        else if (rx_s2_q && qcnt_q == QW'(IDLE_CYCLES - 1))     state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!autobaud_en) state_d = S_IDLE;
        else if (fall)    state_d = S_MEASURE;
      end
      S_MEASURE: begin
        if (!autobaud_en)    state_d = S_IDLE;
        else if (t_ovf)      state_d = S_IDLE;
        else if (final_edge) state_d = S_CALC;
      end
      S_CALC:    state_d = too_fast ? S_IDLE : S_LOAD;
      S_LOAD:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == S_QUIET) || (state_q == S_ARMED) ||
           (state_q == S_MEASURE) || (state_q == S_CALC);
    done = (state_q == S_LOAD);
  end

  // ---------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------
  always_comb begin
    qcnt_d      = qcnt_q;
    t_d         = t_q;
    ecnt_d      = ecnt_q;
    baud_d      = baud_q;
    frac_d      = frac_q;
    gen_rst_n_d = 1'b1;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        qcnt_d = '0;
        if (!autobaud_en) begin
          baud_d = cfg_baud_val;
          frac_d = cfg_fraction;
          // Restart the generator in the same cycle the new value shows up.
          if (cfg_baud_val != baud_q || cfg_fraction != frac_q) gen_rst_n_d = 1'b0;
        end
      end
      S_QUIET: qcnt_d = rx_s2_q ? qcnt_q + QW'(1) : '0;
      S_ARMED: begin
        if (fall) begin
          t_d    = '0;
          ecnt_d = '0;
        end
      end
      S_MEASURE: begin
        // t_d on the final edge is the latched T: the number of cycles
        // between start-edge and final-edge detection.
        t_d = t_inc;
        if (fall) ecnt_d = ecnt_q + 2'd1;
        if (autobaud_en && t_ovf) begin
          err_d       = 1'b1;
          baud_d      = DEFAULT_BAUD_VAL;
          frac_d      = 3'd0;
          gen_rst_n_d = 1'b0;
        end
      end
      S_CALC: begin
        if (too_fast) begin
          err_d = 1'b1;
        end else begin
          baud_d      = div - 13'd1;
          frac_d      = tr[6:4];
          gen_rst_n_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      qcnt_q      <= '0;
      t_q         <= '0;
      ecnt_q      <= '0;
      baud_q      <= DEFAULT_BAUD_VAL;
      frac_q      <= 3'd0;
      gen_rst_n_q <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      qcnt_q      <= qcnt_d;
      t_q         <= t_d;
      ecnt_q      <= ecnt_d;
      baud_q      <= baud_d;
      frac_q      <= frac_d;
      gen_rst_n_q <= gen_rst_n_d;
      err_q       <= err_d;
    end
  end

  assign baud_val          = baud_q;
  assign baud_val_fraction = frac_q;
  assign gen_rst_n         = gen_rst_n_q;
  assign err               = err_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Bench for uart_autobaud_ctrl. u1 has the full 20-bit counter and carries
// the rate table, noise, abort and reset cases. u2 has a 12-bit counter so
// that the stuck-line overflow case completes quickly. u2 also carries the
// manual-mode case.
module tb_uart_autobaud_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rx1, en1, start1;
  logic [12:0] cfg_b1;
  logic [2:0]  cfg_f1;
  logic [12:0] baud1;
  logic [2:0]  frac1;
  logic        grst1, busy1, done1, err1;

  logic        rx2, en2, start2;
  logic [12:0] cfg_b2;
  logic [2:0]  cfg_f2;
  logic [12:0] baud2;
  logic [2:0]  frac2;
  logic        grst2, busy2, done2, err2;

  uart_autobaud_ctrl u1 (
    .clk(clk), .reset(reset), .rx(rx1), .autobaud_en(en1), .start(start1),
    .cfg_baud_val(cfg_b1), .cfg_fraction(cfg_f1), .baud_val(baud1),
    .baud_val_fraction(frac1), .gen_rst_n(grst1), .busy(busy1), .done(done1), .err(err1)
  );

  uart_autobaud_ctrl #(.CNT_W(12)) u2 (
    .clk(clk), .reset(reset), .rx(rx2), .autobaud_en(en2), .start(start2),
    .cfg_baud_val(cfg_b2), .cfg_fraction(cfg_f2), .baud_val(baud2),
    .baud_val_fraction(frac2), .gen_rst_n(grst2), .busy(busy2), .done(done2), .err(err2)
  );

  // Event monitor, sampled on the falling edge.
  int          cyc = 0;
  int          done_cnt1 = 0, err_cnt1 = 0, rst_cnt1 = 0;
  int          err_cnt2 = 0, rst_cnt2 = 0, err_cyc2 = 0;
  logic [12:0] done_baud;
  logic [2:0]  done_frac;
  logic        done_busy, done_rst;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (done1) begin
      done_cnt1 = done_cnt1 + 1;
      done_baud = baud1;
      done_frac = frac1;
      done_busy = busy1;
      done_rst  = grst1;
    end
    if (err1)   err_cnt1 = err_cnt1 + 1;
    if (!grst1) rst_cnt1 = rst_cnt1 + 1;
    if (err2) begin
      err_cnt2 = err_cnt2 + 1;
      err_cyc2 = cyc;
    end
    if (!grst2) rst_cnt2 = rst_cnt2 + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive and sample at negedge + 1 so the monitor has already run.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_start1();
    start1 = 1'b1; tick(1); start1 = 1'b0;
  endtask

  // Frame 8N1, LSB first. Bit k begins at round(k * pm / 1000) cycles,
  // where pm is the bit period in thousandths of a cycle.
  task automatic send_byte(input logic [7:0] b, input longint pm);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      longint t0, t1;
      t0 = (k * pm + 500) / 1000;
      t1 = ((k + 1) * pm + 500) / 1000;
      rx1 = frame[k];
      tick(int'(t1 - t0));
    end
  endtask

  typedef struct {
    string       name;
    longint      pm;
    bit          ok;
    logic [12:0] baud;
    logic [2:0]  frac;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int d0, e0, r0, t0;

    // Each row is a bit period in thousandths of a cycle and the expected
    // result, worked out by hand from T = round(8 * period):
    // Tr = T + 8, baud = Tr/128 - 1, frac = (Tr % 128) / 16.
    vecs[0] = '{"b115200", 64'd434030,  1'b1, 13'd26,  3'd1}; // T=3472
    vecs[1] = '{"fast96",  64'd12000,   1'b0, 13'd26,  3'd1}; // T=96: err, unchanged
    vecs[2] = '{"b9600",   64'd5208333, 1'b1, 13'd324, 3'd4}; // T=41667
    vecs[3] = '{"fast119", 64'd14875,   1'b0, 13'd324, 3'd4}; // T=119: Tr=127, err
    vecs[4] = '{"min120",  64'd15000,   1'b1, 13'd0,   3'd0}; // T=120: Tr=128
    vecs[5] = '{"p200",    64'd200000,  1'b1, 13'd11,  3'd4}; // T=1600

    reset = 1'b1;
    rx1 = 1'b1; en1 = 1'b1; start1 = 1'b0; cfg_b1 = 13'd0; cfg_f1 = 3'd0;
    rx2 = 1'b1; en2 = 1'b0; start2 = 1'b0; cfg_b2 = 13'd26; cfg_f2 = 3'd0;
    tick(3);

    // Reset state
    chk("rst_baud",  baud1, 26);
    chk("rst_frac",  frac1, 0);
    chk("rst_grst",  grst1, 1);
    chk("rst_busy",  busy1, 0);
    chk("rst_done",  done1, 0);
    chk("rst_err",   err1,  0);
    reset = 1'b0;
    tick(3);

    // Manual mode on u2: one cycle of latency, a single restart pulse
    r0 = rst_cnt2;
    cfg_b2 = 13'd100; cfg_f2 = 3'd3;
    chk("man_before", baud2, 26);
    tick(1);
    chk("man_baud",  baud2, 100);
    chk("man_frac",  frac2, 3);
    chk("man_grst0", grst2, 0);
    tick(1);
    chk("man_grst1", grst2, 1);
    tick(3);
    chk("man_npulse", rst_cnt2 - r0, 1);

    // Measurement table on u1
    foreach (vecs[i]) begin
      d0 = done_cnt1; e0 = err_cnt1; r0 = rst_cnt1;
      pulse_start1();
      tick(80);
      send_byte(8'h55, vecs[i].pm);
      tick(20);
      chk({vecs[i].name, "_done"},   done_cnt1 - d0, vecs[i].ok ? 1 : 0);
      chk({vecs[i].name, "_err"},    err_cnt1 - e0,  vecs[i].ok ? 0 : 1);
      chk({vecs[i].name, "_npulse"}, rst_cnt1 - r0,  vecs[i].ok ? 1 : 0);
      chk({vecs[i].name, "_baud"},   baud1, vecs[i].baud);
      chk({vecs[i].name, "_frac"},   frac1, vecs[i].frac);
      chk({vecs[i].name, "_busy"},   busy1, 0);
      if (vecs[i].ok) begin
        chk({vecs[i].name, "_dbaud"}, done_baud, vecs[i].baud);
        chk({vecs[i].name, "_dfrac"}, done_frac, vecs[i].frac);
        chk({vecs[i].name, "_dgrst"}, done_rst,  0);
        chk({vecs[i].name, "_dbusy"}, done_busy, 0);
      end
    end

    // Noise: low glitches every 40 cycles keep the quiet counter from
    // reaching 64, so nothing is measured until the line settles.
    d0 = done_cnt1; e0 = err_cnt1;
    pulse_start1();
    for (int k = 0; k < 6; k++) begin
      rx1 = 1'b0; tick(2);
      rx1 = 1'b1; tick(38);
    end
    chk("noise_busy",  busy1, 1);
    chk("noise_ndone", done_cnt1 - d0, 0);
    tick(100);
    send_byte(8'h55, 64'd434030);
    tick(20);
    chk("noise_done", done_cnt1 - d0, 1);
    chk("noise_err",  err_cnt1 - e0, 0);
    chk("noise_baud", baud1, 26);
    chk("noise_frac", frac1, 1);

    // Stuck line on u2 (12-bit counter): overflow, revert to default
    en2 = 1'b1;
    start2 = 1'b1; tick(1); start2 = 1'b0;
    tick(80);
    e0 = err_cnt2; r0 = rst_cnt2;
    rx2 = 1'b0;
    t0 = cyc;
    while (err_cnt2 == e0 && cyc - t0 < 6000) tick(1);
    chk("stuck_err", err_cnt2 - e0, 1);
    chk("stuck_lat_ok", (err_cyc2 - t0 >= 4090 && err_cyc2 - t0 <= 4106) ? 1 : 0, 1);
    tick(3);
    chk("stuck_baud",   baud2, 26);
    chk("stuck_frac",   frac2, 0);
    chk("stuck_npulse", rst_cnt2 - r0, 1);
    chk("stuck_busy",   busy2, 0);
    rx2 = 1'b1;

    // Abort mid-measure on u1: no err, manual values applied next cycle
    cfg_b1 = 13'd77; cfg_f1 = 3'd2;
    d0 = done_cnt1; e0 = err_cnt1;
    pulse_start1();
    tick(80);
    rx1 = 1'b0;
    tick(300);
    chk("abort_busy1", busy1, 1);
    en1 = 1'b0;
    tick(1);
    chk("abort_busy0", busy1, 0);
    tick(1);
    chk("abort_baud", baud1, 77);
    chk("abort_frac", frac1, 2);
    rx1 = 1'b1;
    tick(10);
    chk("abort_err",  err_cnt1 - e0, 0);
    chk("abort_done", done_cnt1 - d0, 0);

    // Reset during QUIET returns u1 to IDLE with default values
    en1 = 1'b1;
    pulse_start1();
    tick(10);
    chk("mrst_busy1", busy1, 1);
    reset = 1'b1;
    tick(1);
    chk("mrst_busy0", busy1, 0);
    chk("mrst_baud",  baud1, 26);
    chk("mrst_frac",  frac1, 0);
    reset = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
